// File: rtl/draw_pkg.sv
// draw_pkg: shared types and constants for the draw sequencer.
//   op_t    - command opcodes (CLEAR, REULEAUX, two illegal codes)
//   state_t - sequencer FSM states
//   cmd_t   - one queued command {op, colour, x, y, diam}
//   SCREEN_W / SCREEN_H - visible raster size (160x120)
package draw_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR    = 2'd0,
    OP_REULEAUX = 2'd1,
    OP_BAD2     = 2'd2,
    OP_BAD3     = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_RUN     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  typedef struct packed {
    op_t        op;
    logic [2:0] colour;
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] diam;
  } cmd_t;

  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [6:0] SCREEN_H = 7'd120;

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous command FIFO, DEPTH entries (power of two).
// Ports:
//   clk, rst          - clock, asynchronous active-high reset (empties FIFO)
//   push, push_data   - write request; ignored while full
//   pop               - read request; ignored while empty
//   pop_data          - current head entry (valid while !empty)
//   empty, full       - occupancy flags, derived from registered count
module cmd_fifo
  import draw_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = cmd_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     pop_data,
  output logic empty,
  output logic full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  T               mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic           do_push;
  logic           do_pop;

  // Guard both ports so overflow and underflow cannot occur.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign empty    = (count_r == '0);
  assign full     = (count_r == FULL_CNT);
  assign pop_data = mem_r[rd_ptr_r];

  // Storage, pointers (wrap naturally at power-of-two depth) and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else begin
      if (do_push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: queues draw commands and runs them one at a time on either
// the screen-fill engine (CLEAR) or the reuleaux engine (REULEAUX), muxing the
// active engine's pixel stream onto the vga_adapter pixel port.
// Ports:
//   clk, rst                          - clock, async active-high reset
//   cmd_valid/cmd_ready, cmd_*        - command handshake and fields
//   busy, err                         - activity flag, sticky bad-opcode flag
//   fill_start/colour/done, fill_*    - fill engine control and pixel stream
//   shp_start/colour/cx/cy/diam/done  - reuleaux engine control and arguments
//   shp_x/y/vcol/plot                 - reuleaux engine pixel stream
//   vga_x/y/colour/plot               - pixel port (160x120)
// Build option: define DRAW_SEQ_CLIP_EN to suppress vga_plot for pixels
// outside the 160x120 raster (coordinates and colour still pass through).
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [2:0] cmd_colour,
  input  logic [7:0] cmd_x,
  input  logic [6:0] cmd_y,
  input  logic [7:0] cmd_diam,
  output logic       busy,
  output logic       err,
  output logic       fill_start,
  output logic [2:0] fill_colour,
  input  logic       fill_done,
  input  logic [7:0] fill_x,
  input  logic [6:0] fill_y,
  input  logic [2:0] fill_vcol,
  input  logic       fill_plot,
  output logic       shp_start,
  output logic [2:0] shp_colour,
  output logic [7:0] shp_cx,
  output logic [6:0] shp_cy,
  output logic [7:0] shp_diam,
  input  logic       shp_done,
  input  logic [7:0] shp_x,
  input  logic [6:0] shp_y,
  input  logic [2:0] shp_vcol,
  input  logic       shp_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  state_t     state_r;
  op_t        op_r;
  logic [2:0] colour_r;
  logic [7:0] x_r;
  logic [6:0] y_r;
  logic [7:0] diam_r;

  cmd_t       push_cmd;
  cmd_t       head;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       done_sel;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_col;
  logic       sel_plot;

  assign push_cmd = '{op: op_t'(cmd_op), colour: cmd_colour, x: cmd_x,
                      y: cmd_y, diam: cmd_diam};

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (cmd_t)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid && cmd_ready),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state_r != S_IDLE) || !fifo_empty;
  assign pop       = (state_r == S_LAUNCH);
  // Only the selected engine's done can end a command.
  assign done_sel  = (op_r == OP_CLEAR) ? fill_done : shp_done;

  assign fill_colour = colour_r;
  assign shp_colour  = colour_r;
  assign shp_cx      = x_r;
  assign shp_cy      = y_r;
  assign shp_diam    = diam_r;

  // Sequencer FSM: launch head command, hold start until done, one-cycle release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      op_r       <= OP_CLEAR;
      colour_r   <= 3'd0;
      x_r        <= 8'd0;
      y_r        <= 7'd0;
      diam_r     <= 8'd0;
      fill_start <= 1'b0;
      shp_start  <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (!fifo_empty) state_r <= S_LAUNCH;
          else             state_r <= S_IDLE;
        end
        S_LAUNCH: begin
          op_r     <= head.op;
          colour_r <= head.colour;
          x_r      <= head.x;
          y_r      <= head.y;
          diam_r   <= head.diam;
          case (head.op)
            OP_CLEAR: begin
              fill_start <= 1'b1;
              state_r    <= S_RUN;
            end
            OP_REULEAUX: begin
              shp_start <= 1'b1;
              state_r   <= S_RUN;
            end
            default: begin
              err     <= 1'b1;
              state_r <= S_IDLE;
            end
          endcase
        end
        S_RUN: begin
          if (done_sel) begin
            fill_start <= 1'b0;
            shp_start  <= 1'b0;
            state_r    <= S_RELEASE;
          end else begin
            state_r <= S_RUN;
          end
        end
        S_RELEASE: state_r <= S_IDLE;
        default: begin
          fill_start <= 1'b0;
          shp_start  <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

  // Pixel mux: mirror the running engine's stream, otherwise drive zeros.
  always_comb begin
    sel_x    = 8'd0;
    sel_y    = 7'd0;
    sel_col  = 3'd0;
    sel_plot = 1'b0;
    if (state_r == S_RUN) begin
      if (op_r == OP_CLEAR) begin
        sel_x    = fill_x;
        sel_y    = fill_y;
        sel_col  = fill_vcol;
        sel_plot = fill_plot;
      end else begin
        sel_x    = shp_x;
        sel_y    = shp_y;
        sel_col  = shp_vcol;
        sel_plot = shp_plot;
      end
    end else begin
      sel_plot = 1'b0;
    end
  end

  assign vga_x      = sel_x;
  assign vga_y      = sel_y;
  assign vga_colour = sel_col;
`ifdef DRAW_SEQ_CLIP_EN
  assign vga_plot = sel_plot && (sel_x < SCREEN_W) && (sel_y < SCREEN_H);
`else
  assign vga_plot = sel_plot;
`endif

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed self-checking bench for draw_sequencer (FIFO_DEPTH = 4).
module tb_draw_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_colour;
  logic [7:0] cmd_x;
  logic [6:0] cmd_y;
  logic [7:0] cmd_diam;
  logic       busy, err;
  logic       fill_start, fill_done, fill_plot;
  logic [2:0] fill_colour, fill_vcol;
  logic [7:0] fill_x;
  logic [6:0] fill_y;
  logic       shp_start, shp_done, shp_plot;
  logic [2:0] shp_colour, shp_vcol;
  logic [7:0] shp_cx, shp_diam, shp_x;
  logic [6:0] shp_cy, shp_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

  int n_checks = 0;
  int n_fail   = 0;
  logic accepted;
  logic ok;

  draw_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_colour(cmd_colour), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_diam(cmd_diam),
    .busy(busy), .err(err),
    .fill_start(fill_start), .fill_colour(fill_colour), .fill_done(fill_done),
    .fill_x(fill_x), .fill_y(fill_y), .fill_vcol(fill_vcol), .fill_plot(fill_plot),
    .shp_start(shp_start), .shp_colour(shp_colour), .shp_cx(shp_cx),
    .shp_cy(shp_cy), .shp_diam(shp_diam), .shp_done(shp_done),
    .shp_x(shp_x), .shp_y(shp_y), .shp_vcol(shp_vcol), .shp_plot(shp_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [2:0] col,
                          input logic [7:0] x, input logic [6:0] y,
                          input logic [7:0] d);
    logic rdy;
    logic done_push;
    done_push  = 1'b0;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_colour = col;
    cmd_x      = x;
    cmd_y      = y;
    cmd_diam   = d;
    for (int i = 0; i < 20; i++) begin
      rdy = cmd_ready;
      tick();
      if (rdy) begin
        done_push = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    check_eq("push_accepted", {31'd0, done_push}, 32'd1);
  endtask

  task automatic wait_start(input bit shp, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((shp ? shp_start : fill_start) == 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_colour = 3'd0;
    cmd_x = 8'd0; cmd_y = 7'd0; cmd_diam = 8'd0;
    fill_done = 1'b0; fill_x = 8'd0; fill_y = 7'd0; fill_vcol = 3'd0; fill_plot = 1'b0;
    shp_done = 1'b0; shp_x = 8'd0; shp_y = 7'd0; shp_vcol = 3'd0; shp_plot = 1'b0;
    tick(); tick();

    // Reset state
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_err", {31'd0, err}, 32'd0);
    check_eq("rst_starts", {30'd0, fill_start, shp_start}, 32'd0);
    check_eq("rst_vga", {vga_plot, vga_x, vga_y, vga_colour}, 32'd0);
    check_eq("rst_args", {shp_cx, shp_cy, shp_diam, shp_colour}, 32'd0);
    rst = 1'b0;
    tick();

    // CLEAR colour 0: start rises two cycles after acceptance
    push_cmd(2'd0, 3'd0, 8'd0, 7'd0, 8'd0);
    check_eq("clr_start_acc", {31'd0, fill_start}, 32'd0);
    check_eq("clr_busy_q", {31'd0, busy}, 32'd1);
    tick();
    check_eq("clr_start_c1", {31'd0, fill_start}, 32'd0);
    tick();
    check_eq("clr_start_c2", {31'd0, fill_start}, 32'd1);
    check_eq("clr_shp_off", {31'd0, shp_start}, 32'd0);
    check_eq("clr_colour", {29'd0, fill_colour}, 32'd0);
    fill_x = 8'd5; fill_y = 7'd7; fill_vcol = 3'b101; fill_plot = 1'b1;
    #1;
    check_eq("clr_vga_mirror", {vga_plot, vga_x, vga_y, vga_colour},
             {1'b1, 8'd5, 7'd7, 3'b101});
    shp_done = 1'b1;   // wrong engine: must be ignored
    tick();
    shp_done = 1'b0;
    check_eq("clr_ignore_shp_done", {31'd0, fill_start}, 32'd1);
    fill_done = 1'b1;
    tick();
    fill_done = 1'b0;
    check_eq("clr_start_fall", {31'd0, fill_start}, 32'd0);
    check_eq("clr_release_vga", {vga_plot, vga_x}, 32'd0);
    check_eq("clr_busy_release", {31'd0, busy}, 32'd1);
    fill_plot = 1'b0;
    tick();
    check_eq("clr_busy_fall", {31'd0, busy}, 32'd0);

    // REULEAUX centre (80,60) diameter 80 colour 2
    push_cmd(2'd1, 3'b010, 8'd80, 7'd60, 8'd80);
    wait_start(1'b1, "shp_start_seen");
    check_eq("shp_fill_off", {31'd0, fill_start}, 32'd0);
    check_eq("shp_args", {shp_cx, shp_cy, shp_diam, shp_colour},
             {8'd80, 7'd60, 8'd80, 3'b010});
    fill_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("shp_hold", {shp_start, shp_cx, shp_cy, shp_diam},
               {1'b1, 8'd80, 7'd60, 8'd80});
    end
    fill_done = 1'b0;
    shp_x = 8'd170; shp_y = 7'd10; shp_vcol = 3'd3; shp_plot = 1'b1;
    #1;
`ifdef DRAW_SEQ_CLIP_EN
    check_eq("clip_x170", {vga_plot, vga_x, vga_colour}, {1'b0, 8'd170, 3'd3});
`else
    check_eq("pass_x170", {vga_plot, vga_x, vga_colour}, {1'b1, 8'd170, 3'd3});
`endif
    shp_x = 8'd159; shp_y = 7'd119;
    #1;
    check_eq("edge_159_119", {vga_plot, vga_x, vga_y}, {1'b1, 8'd159, 7'd119});
    shp_x = 8'd10; shp_y = 7'd120;
    #1;
`ifdef DRAW_SEQ_CLIP_EN
    check_eq("clip_y120", {vga_plot, vga_y}, {1'b0, 7'd120});
`else
    check_eq("pass_y120", {vga_plot, vga_y}, {1'b1, 7'd120});
`endif
    shp_plot = 1'b0;
    shp_done = 1'b1;
    tick();
    shp_done = 1'b0;
    check_eq("shp_start_fall", {31'd0, shp_start}, 32'd0);
    tick();
    check_eq("shp_busy_fall", {31'd0, busy}, 32'd0);

    // Five commands while the fill engine stalls on an earlier CLEAR
    push_cmd(2'd0, 3'd7, 8'd0, 7'd0, 8'd0);
    wait_start(1'b0, "stall_start_seen");
    for (int i = 1; i <= 4; i++) begin
      push_cmd(2'd1, 3'(i), 8'(10 * i), 7'(i), 8'(i));
    end
    check_eq("full_ready_low", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_colour = 3'd5;
    cmd_x = 8'd50; cmd_y = 7'd5; cmd_diam = 8'd5;
    tick();
    check_eq("full_ready_hold", {31'd0, cmd_ready}, 32'd0);
    fill_done = 1'b1;
    tick();
    fill_done = 1'b0;
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ok = cmd_ready;
      tick();
      if (ok) begin
        accepted = 1'b1;
        break;
      end
    end
    cmd_valid = 1'b0;
    check_eq("fifth_accepted", {31'd0, accepted}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      wait_start(1'b1, "order_start_seen");
      check_eq("order_cx_diam", {16'd0, shp_cx, shp_diam},
               {16'd0, 8'(10 * i), 8'(i)});
      shp_done = 1'b1;
      tick();
      shp_done = 1'b0;
    end
    tick();
    check_eq("order_drained", {30'd0, busy, cmd_ready}, 32'd1);

    // Illegal opcode followed by CLEAR
    push_cmd(2'd3, 3'd1, 8'd0, 7'd0, 8'd0);
    push_cmd(2'd0, 3'd6, 8'd0, 7'd0, 8'd0);
    tick();
    check_eq("bad_err_set", {31'd0, err}, 32'd1);
    check_eq("bad_no_start", {30'd0, fill_start, shp_start}, 32'd0);
    wait_start(1'b0, "bad_clear_runs");
    check_eq("bad_clear_colour", {29'd0, fill_colour}, 32'd6);
    fill_done = 1'b1;
    tick();
    fill_done = 1'b0;
    tick();
    check_eq("bad_err_sticky", {30'd0, err, busy}, 32'd2);

    // Reset mid-RUN with three commands queued
    push_cmd(2'd0, 3'd1, 8'd0, 7'd0, 8'd0);
    wait_start(1'b0, "rr_start_seen");
    push_cmd(2'd0, 3'd2, 8'd0, 7'd0, 8'd0);
    push_cmd(2'd0, 3'd3, 8'd0, 7'd0, 8'd0);
    push_cmd(2'd1, 3'd4, 8'd1, 7'd1, 8'd1);
    check_eq("rr_busy_before", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rr_start_drop", {30'd0, fill_start, shp_start}, 32'd0);
    check_eq("rr_flags", {29'd0, cmd_ready, busy, err}, 32'd4);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check_eq("rr_after", {28'd0, fill_start, shp_start, busy, cmd_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
